// File: rtl/fetch_queue.sv
// Instruction-fetch front end: credit-limited sequential fetch, in-order response queue, redirect flush.
// Optional same-cycle response bypass to decode when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
  parameter int unsigned      XLEN   = 32,
  parameter int unsigned      DEPTH  = 4,
  parameter logic [XLEN-1:0]  RST_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_req_addr,
  input  logic                     imem_resp_valid,
  input  logic [XLEN-1:0]          imem_resp_data,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     inst_valid,
  input  logic                     inst_ready,
  output logic [XLEN-1:0]          inst_data,
  output logic [XLEN-1:0]          inst_pc,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [XLEN-1:0] pc_mem   [DEPTH];
  logic [XLEN-1:0] data_mem [DEPTH];

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] resp_pc_q,  resp_pc_d;
  logic [PW-1:0]   rd_ptr_q,   rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q,   wr_ptr_d;
  logic [CW-1:0]   count_q,    count_d;
  logic [CW-1:0]   live_q,     live_d;
  logic [CW-1:0]   drop_q,     drop_d;

  logic [CW+1:0]   credit_used;
  logic            q_empty;
  logic            req_fire;
  logic            resp_drop;
  logic            resp_take;
  logic            bypass;
  logic            push;
  logic            pop_q;

  always_comb begin
    credit_used    = {2'b00, count_q} + {2'b00, live_q} + {2'b00, drop_q};
    imem_req_valid = !rst && !redirect_valid && (credit_used < (CW+2)'(DEPTH));
    imem_req_addr  = fetch_pc_q;
    req_fire       = imem_req_valid && imem_req_ready;

    q_empty   = (count_q == '0);
    resp_drop = imem_resp_valid && (drop_q != '0);
    resp_take = imem_resp_valid && (drop_q == '0) && (live_q != '0);

`ifdef FETCH_QUEUE_BYPASS_EN
    bypass = resp_take && q_empty && !redirect_valid;
`else
    bypass = 1'b0;
`endif

    inst_valid = !q_empty || bypass;
    inst_data  = bypass ? imem_resp_data : data_mem[rd_ptr_q];
    inst_pc    = bypass ? resp_pc_q      : pc_mem[rd_ptr_q];
    occupancy  = count_q;

    // A bypassed response consumed by decode never touches storage.
    pop_q = inst_valid && inst_ready && !q_empty;
    push  = resp_take && !redirect_valid && !(bypass && inst_ready);

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    live_d     = live_q;
    drop_d     = drop_q;

    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      resp_pc_d  = redirect_pc;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      live_d     = '0;
      // Everything still outstanding is now stale, minus the response retiring this cycle.
      drop_d     = drop_q + live_q - CW'(imem_resp_valid && ((drop_q != '0) || (live_q != '0)));
    end else begin
      if (req_fire)  fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (resp_take) resp_pc_d  = resp_pc_q + XLEN'(4);
      if (push)      wr_ptr_d   = wr_ptr_q + PW'(1);
      if (pop_q)     rd_ptr_d   = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(push) - CW'(pop_q);
      live_d  = live_q + CW'(req_fire) - CW'(resp_take);
      drop_d  = drop_q - CW'(resp_drop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc_q <= RST_PC;
      resp_pc_q  <= RST_PC;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      live_q     <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_q]   <= resp_pc_q;
      data_mem[wr_ptr_q] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table, directed corner sequences, randomized model check.
module tb_fetch_queue;

`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid, inst_ready;
  logic [31:0] inst_data, inst_pc;
  logic [2:0]  occupancy;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_queue #(.XLEN(32), .DEPTH(DEPTH), .RST_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc),
    .occupancy(occupancy)
  );

  function automatic logic [31:0] dfn(input logic [31:0] pc);
    return (pc ^ 32'h5A5A_0000) + 32'h0000_0013;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Waits for the next negedge, drives inputs, then settles 1 time unit before checks.
  task automatic cyc(input logic rq, input logic rv, input logic [31:0] rd,
                     input logic dv, input logic [31:0] dp, input logic ir);
    @(negedge clk);
    imem_req_ready  = rq;
    imem_resp_valid = rv;
    imem_resp_data  = rd;
    redirect_valid  = dv;
    redirect_pc     = dp;
    inst_ready      = ir;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    imem_req_ready = 0; imem_resp_valid = 0; imem_resp_data = '0;
    redirect_valid = 0; redirect_pc = '0; inst_ready = 0;
    #1;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_occ", 32'(occupancy), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("first_req_valid", 32'(imem_req_valid), 32'd1);
    chk("first_req_addr", imem_req_addr, 32'h0);
  endtask

  typedef struct {
    logic rq; logic rv; logic [31:0] rd; logic ir;
    logic e_rv; logic [31:0] e_ra; logic e_iv; logic [31:0] e_pc; logic [2:0] e_occ;
  } vec_t;

  typedef struct { logic [31:0] pc; bit stale; } fl_t;

  vec_t        vt [13];
  fl_t         infl[$];
  logic [31:0] fifo[$];

  initial begin
    // Fill with decode stalled, then drain.
    vt[0]  = '{1,0,32'h0,         0, 1,32'h00,0,32'h0, 0};
    vt[1]  = '{1,1,dfn(32'h0),    0, 1,32'h04,BYP,32'h0, 0};
    vt[2]  = '{1,1,dfn(32'h4),    0, 1,32'h08,1,32'h0, 1};
    vt[3]  = '{1,1,dfn(32'h8),    0, 1,32'h0C,1,32'h0, 2};
    vt[4]  = '{1,1,dfn(32'hC),    0, 0,32'h00,1,32'h0, 3};
    vt[5]  = '{1,0,32'h0,         0, 0,32'h00,1,32'h0, 4};
    vt[6]  = '{1,0,32'h0,         1, 0,32'h00,1,32'h0, 4};
    vt[7]  = '{1,0,32'h0,         1, 1,32'h10,1,32'h4, 3};
    vt[8]  = '{1,1,dfn(32'h10),   1, 1,32'h14,1,32'h8, 2};
    vt[9]  = '{0,1,dfn(32'h14),   1, 1,32'h18,1,32'hC, 2};
    vt[10] = '{0,0,32'h0,         1, 1,32'h18,1,32'h10,2};
    vt[11] = '{0,0,32'h0,         1, 1,32'h18,1,32'h14,1};
    vt[12] = '{0,0,32'h0,         0, 1,32'h18,0,32'h0, 0};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      if (i > 0) @(negedge clk);
      imem_req_ready = vt[i].rq; imem_resp_valid = vt[i].rv; imem_resp_data = vt[i].rd;
      redirect_valid = 0; inst_ready = vt[i].ir;
      #1;
      chk($sformatf("vec%0d_req_valid", i), 32'(imem_req_valid), 32'(vt[i].e_rv));
      if (vt[i].e_rv) chk($sformatf("vec%0d_req_addr", i), imem_req_addr, vt[i].e_ra);
      chk($sformatf("vec%0d_inst_valid", i), 32'(inst_valid), 32'(vt[i].e_iv));
      if (vt[i].e_iv) begin
        chk($sformatf("vec%0d_inst_pc", i), inst_pc, vt[i].e_pc);
        chk($sformatf("vec%0d_inst_data", i), inst_data, dfn(vt[i].e_pc));
      end
      chk($sformatf("vec%0d_occ", i), 32'(occupancy), 32'(vt[i].e_occ));
    end

    // Redirect with two old requests outstanding, first response landing in the redirect cycle.
    do_reset();
    cyc(0,0,0,1,32'h10,0);  chk("rd_req_low_redir", 32'(imem_req_valid), 0);
    cyc(1,0,0,0,0,0);       chk("rd_addr10", imem_req_addr, 32'h10);
    cyc(1,0,0,0,0,0);       chk("rd_addr14", imem_req_addr, 32'h14);
    cyc(1,1,dfn(32'h10),1,32'h100,0); chk("rd_req_low", 32'(imem_req_valid), 0);
    cyc(1,1,dfn(32'h14),0,0,0);
    chk("rd_addr100", imem_req_addr, 32'h100);
    chk("rd_no_stale", 32'(inst_valid), 0);
    cyc(0,1,dfn(32'h100),0,0,0);
    chk("rd_byp_valid", 32'(inst_valid), 32'(BYP));
    cyc(0,0,0,0,0,0);
    chk("rd_valid", 32'(inst_valid), 1);
    chk("rd_pc", inst_pc, 32'h100);
    chk("rd_data", inst_data, dfn(32'h100));
    chk("rd_occ", 32'(occupancy), 1);
    cyc(0,0,0,1,32'h200,1);
    cyc(0,0,0,0,0,0);
    chk("redir_flush_valid", 32'(inst_valid), 0);

    // Address wrap at the top of the space.
    do_reset();
    cyc(0,0,0,1,32'hFFFF_FFFC,0);
    cyc(1,0,0,0,0,0);                  chk("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    cyc(1,0,0,0,0,0);                  chk("wrap_addr_zero", imem_req_addr, 32'h0);
    cyc(0,1,dfn(32'hFFFF_FFFC),0,0,0);
    cyc(0,1,dfn(32'h0),0,0,0);         chk("wrap_pc_top", inst_pc, 32'hFFFF_FFFC);
    cyc(0,0,0,0,0,1);                  chk("wrap_occ", 32'(occupancy), 2);
    cyc(0,0,0,0,0,1);                  chk("wrap_pc_zero", inst_pc, 32'h0);

    // Async reset with 3 queued and 1 in flight; stale response afterwards is ignored.
    do_reset();
    cyc(1,0,0,0,0,0);
    cyc(1,1,dfn(32'h0),0,0,0);
    cyc(1,1,dfn(32'h4),0,0,0);
    cyc(1,1,dfn(32'h8),0,0,0);         chk("mid_addrC", imem_req_addr, 32'hC);
    cyc(0,0,0,0,0,0);                  chk("mid_occ3", 32'(occupancy), 3);
    #2 rst = 1'b1;
    #1;
    chk("async_req_valid", 32'(imem_req_valid), 0);
    chk("async_inst_valid", 32'(inst_valid), 0);
    chk("async_occ", 32'(occupancy), 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    imem_req_ready = 0; imem_resp_valid = 1; imem_resp_data = dfn(32'hC);
    #1;
    chk("post_rst_addr", imem_req_addr, 32'h0);
    chk("post_rst_valid", 32'(inst_valid), 0);
    cyc(0,0,0,0,0,0);
    chk("stale_ignored_occ", 32'(occupancy), 0);
    chk("stale_ignored_valid", 32'(inst_valid), 0);

    // Response latency into an empty queue.
    do_reset();
    cyc(1,0,0,0,0,0);
    cyc(0,1,32'hDEAD_BEEF,0,0,0);
    chk("lat_valid", 32'(inst_valid), 32'(BYP));
    if (BYP) chk("lat_byp_data", inst_data, 32'hDEAD_BEEF);
    cyc(0,0,0,0,0,0);
    chk("lat_valid_next", 32'(inst_valid), 1);
    chk("lat_data_next", inst_data, 32'hDEAD_BEEF);

    // Randomized traffic against a transaction-level model.
    do_reset();
    begin
      logic [31:0] exp_fetch;
      exp_fetch = 32'h0;
      infl.delete(); fifo.delete();
      for (int c = 0; c < 4000; c++) begin
        logic rq, rv, dv, ir, e_rv, acc, byp, e_iv;
        logic [31:0] dp, hpc;
        fl_t r;
        if (c > 0) @(negedge clk);
        dv = ($urandom_range(0, 19) == 0);
        dp = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hC)) : ($urandom & 32'hFFFF_FFFC);
        rq = ($urandom_range(0, 3) != 0);
        ir = ($urandom_range(0, 2) != 0);
        rv = (infl.size() > 0) && ($urandom_range(0, 2) != 0);
        imem_req_ready = rq; imem_resp_valid = rv;
        imem_resp_data = rv ? dfn(infl[0].pc) : $urandom;
        redirect_valid = dv; redirect_pc = dp; inst_ready = ir;
        #1;
        e_rv = !dv && (fifo.size() + infl.size() < DEPTH);
        acc  = rv && !infl[0].stale && !dv;
        byp  = BYP && (fifo.size() == 0) && acc;
        e_iv = (fifo.size() > 0) || byp;
        hpc  = (fifo.size() > 0) ? fifo[0] : (rv ? infl[0].pc : 32'h0);
        chk("rnd_req_valid", 32'(imem_req_valid), 32'(e_rv));
        if (e_rv) chk("rnd_req_addr", imem_req_addr, exp_fetch);
        chk("rnd_inst_valid", 32'(inst_valid), 32'(e_iv));
        if (e_iv) begin
          chk("rnd_inst_pc", inst_pc, hpc);
          chk("rnd_inst_data", inst_data, dfn(hpc));
        end
        chk("rnd_occ", 32'(occupancy), 32'(fifo.size()));
        r = '{32'h0, 1'b1};
        if (rv) r = infl.pop_front();
        if (dv) begin
          foreach (infl[k]) infl[k].stale = 1'b1;
          fifo.delete();
          exp_fetch = dp;
        end else begin
          if (e_iv && ir && fifo.size() > 0) void'(fifo.pop_front());
          if (acc && !(byp && ir)) fifo.push_back(r.pc);
          if (e_rv && rq) begin
            infl.push_back('{exp_fetch, 1'b0});
            exp_fetch = exp_fetch + 32'd4;
          end
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
